seg_disp_scheduler: RTL
=======================

Name: seg_disp_scheduler

Overview:
Controller for the two-digit multiplexed 7-segment display. It stores a 4-bit value per digit and accepts writes from two requesters through a valid/ready port arbitrated round-robin. Requester 0 is the UART digit receiver; requester 1 is a local/debug source. It time-multiplexes the digits with a programmable on-time plus an inter-digit blanking gap (anti-ghosting), and drives the segment and digit-select pins directly.

Parameters:
DIGIT_PERIOD, 1000000, cycles each digit is lit (SHOW phase); must be >= 1
BLANK_CYCLES, 1000, cycles all segments are off before switching digit; 0 disables blanking
CNT_W, 21, width of the scan counter; must hold max(DIGIT_PERIOD, BLANK_CYCLES)

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
rst  in  1  reset, synchronous, active-high
disp_en  in  1  1 = display on; 0 = all segments off
req0_valid  in  1  requester 0 write request
req0_pos  in  1  target digit of requester 0 (0 or 1)
req0_value  in  4  value for requester 0; 0-9 = numeral, 10-15 = dash
req0_ready  out  1  grant to requester 0 (combinational)
req1_valid  in  1  requester 1 write request
req1_pos  in  1  target digit of requester 1
req1_value  in  4  value for requester 1
req1_ready  out  1  grant to requester 1 (combinational)
seg_out  out  7  segment pattern, bit0 = a ... bit6 = g, 1 = lit
digit_sel  out  1  active digit: 0 = digit0, 1 = digit1
scan_tick  out  1  one-cycle pulse on the cycle digit_sel changes

Behaviour:
- One clock (CLK100MHZ), synchronous active-high rst. All outputs are registered except req*_ready.
- Reset values: buf0 = buf1 = 0; state = SHOW; counter = 0; digit_sel = 0; seg_out = 7'b0111111 (glyph '0'); scan_tick = 0; last_grant = 1, so req0 wins the first tie. rst overrides everything, including a write or scan step in the same cycle.
- Decode: 0:0111111, 1:0000110, 2:1011011, 3:1001111, 4:1100110, 5:1101101, 6:1111101, 7:0100111, 8:1111111, 9:1101111; 10-15: 1000000 (dash, segment g).
- Arbiter:
  - Only one requester alone valid -> its ready = 1.
  - Both valid -> ready goes to the requester other than last_grant; the other ready = 0.
  - Neither valid -> both ready = 0.
  - A transfer occurs when valid && ready. On the next edge, buf[pos] <= value and last_grant <= the granted index.
  - Ready does not depend on scan state: there is no backpressure other than arbitration.
  - A requester must hold valid/pos/value stable until it sees ready.
- Scan FSM, states SHOW and BLANK:
  - SHOW: counter increments each cycle. When counter == DIGIT_PERIOD-1:
    - counter <= 0.
    - If BLANK_CYCLES > 0: go to BLANK and set seg_out <= 0.
    - Else: perform a digit switch.
  - BLANK: seg_out held 0 and digit_sel unchanged. When counter == BLANK_CYCLES-1: counter <= 0 and perform a digit switch.
  - Digit switch (enter SHOW): digit_sel <= ~digit_sel; seg_out <= decode(buf[~digit_sel]), masked by disp_en; scan_tick <= 1 for that one cycle.
  - Write bypass: if a transfer targets the incoming digit on the switch cycle, the new value is displayed.
  - Per-digit period = DIGIT_PERIOD + BLANK_CYCLES cycles.
- Writes to the currently lit digit do not change seg_out until that digit's next SHOW entry.
  - Exception: the digit shown straight out of reset also only refreshes at its next SHOW entry.
- disp_en:
  - disp_en = 0 -> seg_out <= 0 on the next edge; scanning and writes continue normally.
  - disp_en rising during SHOW -> seg_out <= decode(buf[digit_sel]) on the next edge.
  - disp_en rising during BLANK -> seg_out stays 0.
- Counter wrap: no free-running wrap; the counter is always cleared at a phase end.

Test Plan:
- Tests use DIGIT_PERIOD = 8 and BLANK_CYCLES = 2 unless stated.
- Reset and scan: assert rst, release, no writes -> seg_out = 0111111 and digit_sel = 0 for 8 cycles; then seg_out = 0 for 2 cycles; then digit_sel = 1, scan_tick = 1 for one cycle, seg_out = 0111111; the pattern repeats every 10 cycles.
- Single write: req0 writes pos = 1, value = 7 during digit0 SHOW -> req0_ready = 1 the same cycle; at the next digit1 SHOW, seg_out = 0100111 while digit0 still shows 0111111.
- Contention: both valid, req0 = (pos0, 3), req1 = (pos0, 5), held -> cycle 1 grants req0, cycle 2 grants req1; buf0 ends at 5 and digit0 displays 1101101. After this, a tie with last_grant = 1 goes to req0.
- Bypass and dash: a write of pos 1, value 12 is accepted on the exact switch cycle into digit1 -> seg_out = 1000000 on that SHOW entry.
- disp_en and rst mid-operation:
  - disp_en = 0 for 15 cycles -> seg_out = 0 throughout while digit_sel still toggles every 10 cycles.
  - rst asserted during BLANK with a write pending -> buffers = 0, digit_sel = 0, seg_out = 0111111, no write applied.
- No-blank config: BLANK_CYCLES = 0, DIGIT_PERIOD = 4 -> digit_sel toggles every 4 cycles and seg_out is never 0 while disp_en = 1.

Source files
------------

// File: rtl/seg_disp_scheduler.sv
// Two-digit multiplexed 7-segment display controller.
// Holds one 4-bit value per digit, accepts writes from two requesters through a
// round-robin arbitrated valid/ready port, and scans the digits with a lit
// phase followed by an all-segments-off blanking gap to avoid ghosting.
module seg_disp_scheduler #(
    parameter int DIGIT_PERIOD = 1000000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 21
) (
    input  logic       CLK100MHZ,
    input  logic       rst,
    input  logic       disp_en,
    input  logic       req0_valid,
    input  logic       req0_pos,
    input  logic [3:0] req0_value,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_pos,
    input  logic [3:0] req1_value,
    output logic       req1_ready,
    output logic [6:0] seg_out,
    output logic       digit_sel,
    output logic       scan_tick
);

    typedef enum logic {SHOW, BLANK} scan_state_t;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [6:0]       GLYPH_ZERO = 7'b0111111;

    scan_state_t      state, state_next;
    logic [CNT_W-1:0] counter, counter_next;
    logic             digit_sel_next;
    logic [6:0]       seg_next;
    logic             tick_next;
    logic             do_switch;
    logic             disp_en_q;
    logic             last_grant;
    logic [3:0]       buf0, buf1;
    logic [3:0]       buf0_next, buf1_next;
    logic             wr_en;
    logic             wr_pos;
    logic [3:0]       wr_value;

    // Values 10-15 have no numeral and show a dash on segment g.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'b0111111;
            4'd1:    g = 7'b0000110;
            4'd2:    g = 7'b1011011;
            4'd3:    g = 7'b1001111;
            4'd4:    g = 7'b1100110;
            4'd5:    g = 7'b1101101;
            4'd6:    g = 7'b1111101;
            4'd7:    g = 7'b0100111;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1101111;
            default: g = 7'b1000000;
        endcase
        return g;
    endfunction

    // Round-robin grant: on a tie the requester that did not win last time goes.
    always_comb begin
        req0_ready = req0_valid && (!req1_valid || last_grant);
        req1_ready = req1_valid && (!req0_valid || !last_grant);
        wr_en      = req0_ready || req1_ready;
        wr_pos     = req0_ready ? req0_pos   : req1_pos;
        wr_value   = req0_ready ? req0_value : req1_value;
    end

    // Post-write buffer contents, so a switch can show a value written that same cycle.
    always_comb begin
        buf0_next = buf0;
        buf1_next = buf1;
        if (wr_en && !wr_pos) buf0_next = wr_value;
        if (wr_en &&  wr_pos) buf1_next = wr_value;
    end

    // Digit buffers and the arbiter's memory of who was granted last.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            buf0       <= 4'd0;
            buf1       <= 4'd0;
            last_grant <= 1'b1;
        end else begin
            buf0 <= buf0_next;
            buf1 <= buf1_next;
            if (wr_en) last_grant <= req1_ready;
        end
    end

    // Scan sequencing: phase timing, digit switching and segment refresh rules.
    always_comb begin
        state_next     = state;
        counter_next   = counter + CNT_W'(1);
        digit_sel_next = digit_sel;
        seg_next       = seg_out;
        tick_next      = 1'b0;
        do_switch      = 1'b0;
        case (state)
            SHOW: begin
                if (counter == SHOW_LAST) begin
                    counter_next = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_next = BLANK;
                        seg_next   = '0;
                    end else begin
                        do_switch = 1'b1;
                    end
                end else if (!disp_en) begin
                    seg_next = '0;
                end else if (!disp_en_q) begin
                    seg_next = decode(digit_sel ? buf1 : buf0);
                end
            end
            BLANK: begin
                seg_next = '0;
                if (counter == BLANK_LAST) begin
                    counter_next = '0;
                    do_switch    = 1'b1;
                end
            end
            default: state_next = SHOW;
        endcase
        if (do_switch) begin
            state_next     = SHOW;
            digit_sel_next = ~digit_sel;
            seg_next       = disp_en ? decode(digit_sel ? buf0_next : buf1_next) : 7'd0;
            tick_next      = 1'b1;
        end
    end

    // Scan state register and registered display outputs.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state     <= SHOW;
            counter   <= '0;
            digit_sel <= 1'b0;
            seg_out   <= GLYPH_ZERO;
            scan_tick <= 1'b0;
            disp_en_q <= 1'b1;
        end else begin
            state     <= state_next;
            counter   <= counter_next;
            digit_sel <= digit_sel_next;
            seg_out   <= seg_next;
            scan_tick <= tick_next;
            disp_en_q <= disp_en;
        end
    end

endmodule
